// File: rtl/walk_request_arbiter.sv
// Pedestrian walk-request front end: per-channel synchronise, debounce,
// pending latch and wait-age, then one-at-a-time grant offer to the traffic
// light controller FSM (urgent channels first, otherwise round-robin).
module walk_request_arbiter #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WAIT_W          = 8,
  parameter int MAX_WAIT        = 200,
  localparam int IDX_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_CH-1:0]  walk_push,
  input  logic [N_CH-1:0]  clear_by_fsm,
  output logic [N_CH-1:0]  pending_walk,
  output logic [N_CH-1:0]  urgent,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_urgent,
  input  logic             grant_ready
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int URG_W = WAIT_W + 1;

  localparam logic [DB_W-1:0]   DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [WAIT_W-1:0] AGE_MAX = '1;
  localparam logic [URG_W-1:0]  URG_TH  = URG_W'(MAX_WAIT);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Input path
  logic [N_CH-1:0]   walkSync_p0;
  logic [N_CH-1:0]   walkSync_p1;
  logic [DB_W-1:0]   dbCnt [N_CH];
  logic [N_CH-1:0]   stable;
  logic [N_CH-1:0]   stableQ;
  logic [N_CH-1:0]   pressEvt;

  // Pending / age
  logic [N_CH-1:0]   pendQ;
  logic [N_CH-1:0]   pendNext;
  logic [N_CH-1:0]   acceptVec;
  logic [WAIT_W-1:0] age [N_CH];

  // Grant FSM
  state_t            state;
  state_t            stateNext;
  logic [IDX_W-1:0]  rrPtr;
  logic [IDX_W-1:0]  rrPtrNext;
  logic [IDX_W-1:0]  grantIdxQ;
  logic [IDX_W-1:0]  grantIdxNext;
  logic              grantUrgQ;
  logic              grantUrgNext;

  // Selection
  logic [N_CH-1:0]   eligible;
  logic              selFound;
  logic [IDX_W-1:0]  selIdx;
  logic              selUrg;

  // Saturating increment of a debounce counter (stops at the accept count).
  function automatic logic [DB_W-1:0] satIncDb(input logic [DB_W-1:0] v);
    if (v == DB_MAX) return v;
    return v + 1'b1;
  endfunction

  // Saturating increment of a wait-age counter (stops at all-ones).
  function automatic logic [WAIT_W-1:0] satIncAge(input logic [WAIT_W-1:0] v);
    if (v == AGE_MAX) return v;
    return v + 1'b1;
  endfunction

  // Next round-robin position after a channel, wrapping at N_CH.
  function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= N_CH - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchroniser on the raw buttons.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      walkSync_p0 <= '0;
      walkSync_p1 <= '0;
    end else begin
      walkSync_p0 <= walk_push;
      walkSync_p1 <= walkSync_p0;
    end
  end

  // Debounce: count consecutive high synced samples, restart on any low one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!reset_n) begin
        dbCnt[i]   <= '0;
        stableQ[i] <= 1'b0;
      end else begin
        stableQ[i] <= stable[i];
        if (!walkSync_p1[i]) dbCnt[i] <= '0;
        else                 dbCnt[i] <= satIncDb(dbCnt[i]);
      end
    end
  end

  // A press is the rising edge of the debounced level; holding never re-fires.
  always_comb begin
    stable = '0;
    for (int i = 0; i < N_CH; i++) begin
      stable[i] = (dbCnt[i] == DB_MAX);
    end
    pressEvt = stable & ~stableQ;
  end

  // Pending latch next value: clear beats accept beats press, else hold.
  always_comb begin
    acceptVec = '0;
    pendNext  = pendQ;
    for (int i = 0; i < N_CH; i++) begin
      if ((state == OFFER) && grant_ready && (int'(grantIdxQ) == i)) acceptVec[i] = 1'b1;
      if (clear_by_fsm[i])  pendNext[i] = 1'b0;
      else if (acceptVec[i]) pendNext[i] = 1'b0;
      else if (pressEvt[i])  pendNext[i] = 1'b1;
    end
  end

  // Pending register.
  always_ff @(posedge clk) begin
    if (!reset_n) pendQ <= '0;
    else          pendQ <= pendNext;
  end

  // Wait age: zero while idle or on the clearing edge, saturating count while pending.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!reset_n)                     age[i] <= '0;
      else if (!pendNext[i] || !pendQ[i]) age[i] <= '0;
      else                              age[i] <= satIncAge(age[i]);
    end
  end

  // Urgent flag: pending and aged to the threshold.
  always_comb begin
    urgent = '0;
    for (int i = 0; i < N_CH; i++) begin
      urgent[i] = pendQ[i] && ({1'b0, age[i]} >= URG_TH);
    end
  end

  // Channel selection from rrPtr with wrap: first urgent, else first pending.
  // A channel being cleared this very cycle is skipped so we never offer it.
  always_comb begin
    logic             urgFound;
    logic             anyFound;
    logic [IDX_W-1:0] urgIdx;
    logic [IDX_W-1:0] anyIdx;
    urgFound = 1'b0;
    anyFound = 1'b0;
    urgIdx   = '0;
    anyIdx   = '0;
    eligible = pendQ & ~clear_by_fsm;
    for (int off = 0; off < N_CH; off++) begin
      int ch;
      ch = int'(rrPtr) + off;
      if (ch >= N_CH) ch = ch - N_CH;
      if (eligible[ch] && urgent[ch] && !urgFound) begin
        urgFound = 1'b1;
        urgIdx   = IDX_W'(ch);
      end
      if (eligible[ch] && !anyFound) begin
        anyFound = 1'b1;
        anyIdx   = IDX_W'(ch);
      end
    end
    selFound = anyFound;
    selUrg   = urgFound;
    selIdx   = urgFound ? urgIdx : anyIdx;
  end

  // Grant FSM next state: offer on any eligible request, retire on accept or withdraw.
  always_comb begin
    stateNext    = state;
    rrPtrNext    = rrPtr;
    grantIdxNext = grantIdxQ;
    grantUrgNext = grantUrgQ;
    case (state)
      IDLE: begin
        if (selFound) begin
          stateNext    = OFFER;
          grantIdxNext = selIdx;
          grantUrgNext = selUrg;
        end
      end
      OFFER: begin
        if (grant_ready) begin
          stateNext = IDLE;
          rrPtrNext = wrapInc(grantIdxQ);
        end else if (clear_by_fsm[grantIdxQ]) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Grant FSM registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rrPtr     <= '0;
      grantIdxQ <= '0;
      grantUrgQ <= 1'b0;
    end else begin
      state     <= stateNext;
      rrPtr     <= rrPtrNext;
      grantIdxQ <= grantIdxNext;
      grantUrgQ <= grantUrgNext;
    end
  end

  assign pending_walk = pendQ;
  assign grant_valid  = (state == OFFER);
  assign grant_idx    = grantIdxQ;
  assign grant_urgent = grantUrgQ;

endmodule

// File: tb/tb_walk_request_arbiter.sv
// Directed bench for walk_request_arbiter (N_CH=4, DEBOUNCE_CYCLES=4, MAX_WAIT=20).
module tb_walk_request_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] walk_push;
  logic [3:0] clear_by_fsm;
  logic [3:0] pending_walk;
  logic [3:0] urgent;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       grant_urgent;
  logic       grant_ready;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  walk_request_arbiter #(
    .N_CH(4), .DEBOUNCE_CYCLES(4), .WAIT_W(8), .MAX_WAIT(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .walk_push(walk_push),
    .clear_by_fsm(clear_by_fsm), .pending_walk(pending_walk),
    .urgent(urgent), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .grant_urgent(grant_urgent), .grant_ready(grant_ready)
  );

  task automatic chkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs/outputs touched 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    reset_n      = 1'b0;
    walk_push    = '0;
    clear_by_fsm = '0;
    grant_ready  = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic sawValid;
    reset_n      = 1'b0;
    walk_push    = '0;
    clear_by_fsm = '0;
    grant_ready  = 1'b0;

    // Reset state
    doReset();
    chkEq("rst_pending", pending_walk, 4'b0000);
    chkEq("rst_urgent",  urgent, 4'b0000);
    chkEq("rst_valid",   grant_valid, 0);
    chkEq("rst_idx",     grant_idx, 0);
    chkEq("rst_gurg",    grant_urgent, 0);

    // 1: 3-cycle glitch on ch2 is ignored
    walk_push = 4'b0100;
    tick(3);
    walk_push = 4'b0000;
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (grant_valid) sawValid = 1'b1;
    end
    chkEq("t1_pending", pending_walk, 4'b0000);
    chkEq("t1_novalid", sawValid, 0);

    // 2: held press on ch1, latency and absorbed re-press
    doReset();
    walk_push = 4'b0010;
    tick(6);
    chkEq("t2_pend_early", pending_walk, 4'b0000);
    tick(1);
    chkEq("t2_pend_k6", pending_walk, 4'b0010);
    chkEq("t2_valid_k6", grant_valid, 0);
    tick(1);
    chkEq("t2_valid", grant_valid, 1);
    chkEq("t2_idx", grant_idx, 1);
    chkEq("t2_gurg", grant_urgent, 0);
    tick(2);
    walk_push = 4'b0000;
    tick(3);
    walk_push = 4'b0010;
    tick(8);
    chkEq("t2_repress_pend", pending_walk, 4'b0010);
    chkEq("t2_repress_valid", grant_valid, 1);
    chkEq("t2_repress_idx", grant_idx, 1);
    grant_ready = 1'b1;
    tick(1);
    grant_ready = 1'b0;
    chkEq("t2_acc_pend", pending_walk, 4'b0000);
    chkEq("t2_acc_valid", grant_valid, 0);
    tick(3);
    chkEq("t2_single_pend", pending_walk, 4'b0000);
    chkEq("t2_single_valid", grant_valid, 0);
    walk_push = 4'b0000;

    // 3: ch0, ch2, ch3 served round-robin with a gap between grants
    doReset();
    walk_push = 4'b1101;
    tick(7);
    chkEq("t3_pend", pending_walk, 4'b1101);
    walk_push   = 4'b0000;
    grant_ready = 1'b1;
    tick(1);
    chkEq("t3_g0_valid", grant_valid, 1);
    chkEq("t3_g0_idx", grant_idx, 0);
    tick(1);
    chkEq("t3_gap0", grant_valid, 0);
    chkEq("t3_pend0", pending_walk, 4'b1100);
    tick(1);
    chkEq("t3_g1_valid", grant_valid, 1);
    chkEq("t3_g1_idx", grant_idx, 2);
    tick(1);
    chkEq("t3_gap1", grant_valid, 0);
    chkEq("t3_pend1", pending_walk, 4'b1000);
    tick(1);
    chkEq("t3_g2_valid", grant_valid, 1);
    chkEq("t3_g2_idx", grant_idx, 3);
    tick(1);
    chkEq("t3_gap2", grant_valid, 0);
    chkEq("t3_pend_end", pending_walk, 4'b0000);
    grant_ready = 1'b0;

    // 4: ageing to urgent, urgent beats round-robin
    doReset();
    walk_push = 4'b1000;
    tick(7);
    walk_push = 4'b0000;
    tick(1);
    chkEq("t4_idx3", grant_idx, 3);
    chkEq("t4_gurg3", grant_urgent, 0);
    tick(18);
    chkEq("t4_age19", urgent, 4'b0000);
    tick(1);
    chkEq("t4_age20", urgent, 4'b1000);
    chkEq("t4_gurg_hold", grant_urgent, 0);
    chkEq("t4_idx_hold", grant_idx, 3);
    walk_push = 4'b0010;
    tick(7);
    chkEq("t4_pend31", pending_walk, 4'b1010);
    walk_push = 4'b0000;
    tick(20);
    chkEq("t4_urg31", urgent, 4'b1010);
    walk_push = 4'b0001;
    tick(7);
    chkEq("t4_pend310", pending_walk, 4'b1011);
    walk_push   = 4'b0000;
    grant_ready = 1'b1;
    tick(1);
    grant_ready = 1'b0;
    chkEq("t4_acc3_pend", pending_walk, 4'b0011);
    chkEq("t4_acc3_valid", grant_valid, 0);
    tick(1);
    chkEq("t4_urgsel_idx", grant_idx, 1);
    chkEq("t4_urgsel_gurg", grant_urgent, 1);
    grant_ready = 1'b1;
    tick(1);
    grant_ready = 1'b0;
    chkEq("t4_acc1_pend", pending_walk, 4'b0001);
    tick(1);
    chkEq("t4_ch0_valid", grant_valid, 1);
    chkEq("t4_ch0_idx", grant_idx, 0);
    chkEq("t4_ch0_gurg", grant_urgent, 0);

    // 5: clear beats a simultaneous press; clear during offer withdraws it
    doReset();
    walk_push = 4'b0001;
    tick(6);
    clear_by_fsm = 4'b0001;
    tick(1);
    chkEq("t5_clear_press", pending_walk, 4'b0000);
    clear_by_fsm = 4'b0000;
    tick(4);
    chkEq("t5_lost_pend", pending_walk, 4'b0000);
    chkEq("t5_lost_valid", grant_valid, 0);
    walk_push = 4'b0100;
    tick(7);
    walk_push = 4'b0000;
    tick(1);
    chkEq("t5_offer_valid", grant_valid, 1);
    chkEq("t5_offer_idx", grant_idx, 2);
    clear_by_fsm = 4'b0100;
    tick(1);
    clear_by_fsm = 4'b0000;
    chkEq("t5_withdraw_valid", grant_valid, 0);
    chkEq("t5_withdraw_pend", pending_walk, 4'b0000);
    tick(2);
    chkEq("t5_idle_valid", grant_valid, 0);

    // 6: reset mid-handshake restores rr_ptr to 0
    walk_push = 4'b0100;
    tick(7);
    walk_push = 4'b0000;
    tick(1);
    grant_ready = 1'b1;
    tick(1);
    grant_ready = 1'b0;
    walk_push = 4'b0010;
    tick(7);
    walk_push = 4'b0000;
    tick(1);
    chkEq("t6_pre_valid", grant_valid, 1);
    chkEq("t6_pre_idx", grant_idx, 1);
    reset_n     = 1'b0;
    grant_ready = 1'b1;
    tick(1);
    chkEq("t6_rst_pending", pending_walk, 4'b0000);
    chkEq("t6_rst_urgent", urgent, 4'b0000);
    chkEq("t6_rst_valid", grant_valid, 0);
    chkEq("t6_rst_idx", grant_idx, 0);
    chkEq("t6_rst_gurg", grant_urgent, 0);
    reset_n     = 1'b1;
    grant_ready = 1'b0;
    walk_push   = 4'b1001;
    tick(7);
    chkEq("t6_pend", pending_walk, 4'b1001);
    walk_push = 4'b0000;
    tick(1);
    chkEq("t6_post_valid", grant_valid, 1);
    chkEq("t6_post_idx", grant_idx, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
